// File: rtl/shift_exec_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_exec_pipe: two-stage 16-bit shift/rotate unit over valid/ready   |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module shift_exec_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_op,
  input  logic [3:0]  in_amt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  localparam logic [1:0] C_OP_ROR = 2'b10;
  localparam logic [1:0] C_OP_SRL = 2'b11;

  function automatic logic [15:0] bitrev16(input logic [15:0] d);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = d[15-i];
    return r;
  endfunction

  logic        r_s1_valid;
  logic [15:0] r_s1_data;
  logic [3:0]  r_s1_amt;
  logic        r_s1_shift;
  logic        r_s1_rev;
  logic        r_s2_valid;
  logic [15:0] r_s2_data;

  logic        w_s2_adv;
  logic        w_s1_adv;
  logic        w_in_fire;
  logic [15:0] w_pre_data;
  logic [3:0]  w_pre_amt;
  logic        w_pre_shift;
  logic        w_pre_rev;
  logic [31:0] w_rot_dbl;
  logic [15:0] w_core;
  logic [15:0] w_result;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign w_in_fire = in_valid && w_s1_adv && !flush;

  // Right-going ops reuse the left-only core: ROR via negated amount, SRL via bit reversal.
  always_comb begin
    w_pre_data  = in_data;
    w_pre_amt   = in_amt;
    w_pre_shift = in_op[0];
    w_pre_rev   = 1'b0;
    case (in_op)
      C_OP_ROR: w_pre_amt = 4'd0 - in_amt;
      C_OP_SRL: begin
        w_pre_data = bitrev16(in_data);
        w_pre_rev  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_rot_dbl = {r_s1_data, r_s1_data} << r_s1_amt;
  assign w_core    = r_s1_shift ? (r_s1_data << r_s1_amt) : w_rot_dbl[31:16];
  assign w_result  = r_s1_rev ? bitrev16(w_core) : w_core;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= 16'h0000;
      r_s1_amt   <= 4'd0;
      r_s1_shift <= 1'b0;
      r_s1_rev   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= 16'h0000;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
      end else begin
        if (w_s1_adv) r_s1_valid <= in_valid;
        if (w_s2_adv) r_s2_valid <= r_s1_valid;
      end
      if (w_in_fire) begin
        r_s1_data  <= w_pre_data;
        r_s1_amt   <= w_pre_amt;
        r_s1_shift <= w_pre_shift;
        r_s1_rev   <= w_pre_rev;
      end
      // Result data is left untouched by flush so the last value stays visible.
      if (w_s2_adv && r_s1_valid && !flush) r_s2_data <= w_result;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;

endmodule
`default_nettype wire

// File: tb/tb_shift_exec_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shift_exec_pipe: directed vectors and stream sequences             |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_shift_exec_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic [1:0]  in_op = 2'b00;
  logic [3:0]  in_amt = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;

  shift_exec_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] exp;
  } vec_t;

  localparam logic [1:0] ROL = 2'b00, SLL = 2'b01, ROR = 2'b10, SRL = 2'b11;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  vec_t vecs[16];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Independent reference written with plain right/left shifts.
  function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] op, input logic [3:0] a);
    int s = int'(a);
    case (op)
      ROL:     return (d << s) | (d >> (16 - s));
      SLL:     return d << s;
      ROR:     return (d >> s) | (d << (16 - s));
      default: return d >> s;
    endcase
  endfunction

  // One cycle: drive at negedge, sample just after, score the upcoming edge's transfers.
  task automatic step(input logic v, input logic [15:0] d, input logic [1:0] op,
                      input logic [3:0] a, input logic ordy, input logic fl,
                      output logic acc, output logic got);
    @(negedge clk);
    in_valid = v; in_data = d; in_op = op; in_amt = a; out_ready = ordy; flush = fl;
    #1;
    acc = v && in_ready && !fl;
    got = out_valid && ordy;
    if (got) begin
      chk("out_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) chk("stream_data", out_data, exp_q.pop_front());
    end
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back(model(d, op, a));
  endtask

  task automatic drain();
    logic acc, got;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step(0, 0, 0, 0, 1, 0, acc, got);
    chk("drain_empty", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc, got;
    int idx;
    int acc_cnt;
    logic [15:0] held;
    logic held_ok;

    vecs[0]  = '{16'h8001, ROL, 4'd4,  16'h0018};
    vecs[1]  = '{16'h8001, SLL, 4'd4,  16'h0010};
    vecs[2]  = '{16'h8001, SRL, 4'd4,  16'h0800};
    vecs[3]  = '{16'h8001, ROR, 4'd1,  16'hC000};
    vecs[4]  = '{16'hA5C3, ROL, 4'd0,  16'hA5C3};
    vecs[5]  = '{16'hA5C3, SLL, 4'd0,  16'hA5C3};
    vecs[6]  = '{16'hA5C3, ROR, 4'd0,  16'hA5C3};
    vecs[7]  = '{16'hA5C3, SRL, 4'd0,  16'hA5C3};
    vecs[8]  = '{16'h0001, ROR, 4'd15, 16'h0002};
    vecs[9]  = '{16'hFFFF, SLL, 4'd15, 16'h8000};
    vecs[10] = '{16'hFFFF, SRL, 4'd15, 16'h0001};
    vecs[11] = '{16'h1234, ROL, 4'd8,  16'h3412};
    vecs[12] = '{16'h1234, ROR, 4'd4,  16'h4123};
    vecs[13] = '{16'h00F1, SLL, 4'd3,  16'h0788};
    vecs[14] = '{16'h8000, ROL, 4'd15, 16'h4000};
    vecs[15] = '{16'hABCD, ROR, 4'd8,  16'hCDAB};

    // Reset state
    #2;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 16'(in_ready), 16'd1);

    // Directed vectors: exact two-cycle latency
    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = 1; in_data = vecs[i].d; in_op = vecs[i].op; in_amt = vecs[i].amt; out_ready = 1;
      #1 chk("vec_in_ready", 16'(in_ready), 16'd1);
      @(negedge clk);
      in_valid = 0;
      #1 chk("vec_lat1_valid", 16'(out_valid), 16'd0);
      @(negedge clk);
      #1 chk("vec_valid", 16'(out_valid), 16'd1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
    end
    step(0, 0, 0, 0, 1, 0, acc, got);

    // Back-to-back eight requests, one result per cycle
    for (int c = 0; c < 10; c++) begin
      step(c < 8, 16'h0001, ROL, 4'(c), 1, 0, acc, got);
      chk("b2b_out_cycle", 16'(got), 16'(c >= 2));
    end
    drain();

    // Stall: out_ready low for five cycles with a stream behind it
    idx = 0; acc_cnt = 0; held_ok = 0; held = 16'h0;
    for (int c = 0; c < 5; c++) begin
      step(1, 16'h1001 + 16'(idx * 16'h0111), SRL, 4'(idx + 1), 0, 0, acc, got);
      if (out_valid) begin
        if (held_ok) chk("stall_hold_data", out_data, held);
        held = out_data; held_ok = 1;
      end
      if (acc) begin idx++; acc_cnt++; end
    end
    chk("stall_accepts", 16'(acc_cnt), 16'd2);
    chk("stall_in_ready", 16'(in_ready), 16'd0);
    chk("stall_out_valid", 16'(out_valid), 16'd1);
    for (int c = 0; c < 20 && idx < 6; c++) begin
      step(1, 16'h1001 + 16'(idx * 16'h0111), SRL, 4'(idx + 1), 1, 0, acc, got);
      if (acc) idx++;
    end
    chk("stall_all_sent", 16'(idx), 16'd6);
    drain();

    // Flush with both stages full and a pending request
    step(1, 16'h00AA, SLL, 4'd1, 0, 0, acc, got);
    step(1, 16'h00BB, SLL, 4'd2, 0, 0, acc, got);
    step(1, 16'h00CC, SLL, 4'd3, 0, 1, acc, got);
    step(0, 0, 0, 0, 1, 0, acc, got);
    chk("flush_out_valid", 16'(out_valid), 16'd0);
    // Flush beats an accepted-looking request on an empty pipe
    step(1, 16'h00DD, SLL, 4'd4, 1, 1, acc, got);
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0, 0, 1, 0, acc, got);
      chk("flush_no_out", 16'(out_valid), 16'd0);
    end
    step(1, 16'h0F0F, ROL, 4'd4, 1, 0, acc, got);
    drain();

    // Asynchronous reset mid-stream
    step(1, 16'h1357, ROL, 4'd3, 1, 0, acc, got);
    step(1, 16'h2468, SLL, 4'd2, 1, 0, acc, got);
    step(1, 16'h369C, ROR, 4'd5, 1, 0, acc, got);
    @(posedge clk); #3;
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 16'(out_valid), 16'd0);
    chk("arst_out_data", out_data, 16'h0000);
    chk("arst_in_ready", 16'(in_ready), 16'd1);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 1, 0, acc, got);
      chk("arst_no_out", 16'(out_valid), 16'd0);
    end
    step(1, 16'hC001, SRL, 4'd2, 1, 0, acc, got);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
